// File: rtl/inport_pkg.sv
// Shared definitions for the input-port per-VC state bank: state encoding,
// state-field width and the pointer-width helper used by the arbiter.
package inport_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE    = 2'd0,
    ROUTE   = 2'd1,
    VCALLOC = 2'd2,
    ACTIVE  = 2'd3
  } vc_state_e;

  // A 1-wide pointer is still needed when only one requester exists.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inport_vc_state_if.sv
// Bundle of per-VC handshake/status signals between the link logic, the
// shared route unit, the VC allocator and the per-VC state bank.
interface inport_vc_state_if #(
  parameter int NUM_VC = 4
);

  logic [NUM_VC-1:0]   hs_done;
  logic                rc_done;
  logic [NUM_VC-1:0]   vc_done;
  logic [NUM_VC-1:0]   all_done;
  logic [2*NUM_VC-1:0] state;
  logic [NUM_VC-1:0]   rc_gnt;
  logic                rc_busy;
  logic [NUM_VC-1:0]   vc_reset;
  logic [NUM_VC-1:0]   wd_err;

  modport master (
    output hs_done, rc_done, vc_done, all_done,
    input  state, rc_gnt, rc_busy, vc_reset, wd_err
  );

  modport slave (
    input  hs_done, rc_done, vc_done, all_done,
    output state, rc_gnt, rc_busy, vc_reset, wd_err
  );

endinterface

// File: rtl/inport_vc_state_rr_arbiter.sv
// Round-robin arbiter for the shared route unit: registered one-hot grant,
// held until released, pointer moves past the winner on release.
module rr_arbiter
  import inport_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rs_n,
  input  logic [N-1:0] req,
  input  logic         rel,
  output logic [N-1:0] gnt,
  output logic         busy
);

  localparam int PW = ptr_w(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] gidx;
  logic [PW-1:0] nxt_ptr;
  logic [N-1:0]  pick;

  // Scan downward so the request closest above the pointer is written last.
  always_comb begin
    int idx;
    idx  = 0;
    pick = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % N;
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gidx = PW'(i);
    end
  end

  assign nxt_ptr = (int'(gidx) == N - 1) ? '0 : gidx + PW'(1);
  assign busy    = |gnt;

  // A release edge never issues a new grant, leaving one idle cycle between owners.
  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      gnt   <= '0;
      ptr_q <= '0;
    end else if (busy && rel) begin
      gnt   <= '0;
      ptr_q <= nxt_ptr;
    end else if (!busy) begin
      gnt   <= pick;
    end
  end

endmodule

// File: rtl/inport_vc_state.sv
// Per-VC IDLE/ROUTE/VCALLOC/ACTIVE state bank for a router input port with a
// shared, round-robin arbitrated route unit. INPORT_WATCHDOG_EN adds a ROUTE/VCALLOC timeout.
//
// state   | meaning
// IDLE    | no packet, waiting for head-flit handshake
// ROUTE   | waiting for (or holding) the shared route unit
// VCALLOC | route known, waiting for output VC allocation
// ACTIVE  | flits flowing until the tail leaves
module inport_vc_state
  import inport_pkg::*;
#(
  parameter int NUM_VC    = 4,
  parameter int WD_CYCLES = 64,
  parameter int WD_W      = 8
) (
  input  logic               clk,
  input  logic               rs_n,
  inport_vc_state_if.slave   bus
);

  if (NUM_VC < 2 || NUM_VC > 16) begin : g_bad_num_vc
    $error("inport_vc_state: NUM_VC must be 2..16");
  end
  if ((1 << WD_W) <= WD_CYCLES) begin : g_bad_wd
    $error("inport_vc_state: WD_W too narrow for WD_CYCLES");
  end

  logic [NUM_VC-1:0] req;
  logic [NUM_VC-1:0] abort;
  logic              rel;

  // A watchdog abort of the owning VC frees the route unit exactly like rc_done.
  assign rel = bus.rc_busy & (bus.rc_done | (|(abort & bus.rc_gnt)));

  rr_arbiter #(.N(NUM_VC)) u_arb (
    .clk  (clk),
    .rs_n (rs_n),
    .req  (req),
    .rel  (rel),
    .gnt  (bus.rc_gnt),
    .busy (bus.rc_busy)
  );

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_state_e st_q;
    vc_state_e st_d;

    always_comb begin
      st_d = st_q;
      unique case (st_q)
        IDLE:    if (bus.hs_done[v])                st_d = ROUTE;
        ROUTE:   if (bus.rc_done && bus.rc_gnt[v])  st_d = VCALLOC;
        VCALLOC: if (bus.vc_done[v])                st_d = ACTIVE;
        ACTIVE:  if (bus.all_done[v])               st_d = IDLE;
        default:                                    st_d = IDLE;
      endcase
      if (abort[v]) st_d = IDLE;
    end

    always_ff @(posedge clk or negedge rs_n) begin
      if (!rs_n) st_q <= IDLE;
      else       st_q <= st_d;
    end

    assign bus.state[ST_W*v +: ST_W] = st_q;
    assign bus.vc_reset[v]           = (st_q == ACTIVE && bus.all_done[v]) || !rs_n;
    assign req[v]                    = (st_q == ROUTE) && !abort[v];

`ifdef INPORT_WATCHDOG_EN
    logic [WD_W-1:0] wd_q;
    logic            watched;
    logic            wd_err_q;

    assign watched  = (st_q == ROUTE) || (st_q == VCALLOC);
    assign abort[v] = watched && (wd_q == WD_W'(WD_CYCLES - 1));

    // Any state change restarts the count, so each watched phase gets a fresh budget.
    always_ff @(posedge clk or negedge rs_n) begin
      if (!rs_n) begin
        wd_q     <= '0;
        wd_err_q <= 1'b0;
      end else begin
        wd_err_q <= abort[v];
        if (st_d != st_q) wd_q <= '0;
        else if (watched) wd_q <= wd_q + WD_W'(1);
      end
    end

    assign bus.wd_err[v] = wd_err_q;
`else
    assign abort[v]      = 1'b0;
    assign bus.wd_err[v] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_inport_vc_state.sv
// Scoreboard bench for inport_vc_state (NUM_VC=4): expected per-cycle results
// are queued as each stimulus vector is driven and compared after the edge.
module tb_inport_vc_state;

  logic clk;
  logic rs_n;

  inport_vc_state_if #(.NUM_VC(4)) bus ();

  inport_vc_state #(.NUM_VC(4), .WD_CYCLES(64), .WD_W(8)) dut (
    .clk  (clk),
    .rs_n (rs_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] hs;
    logic       rc;
    logic [3:0] vd;
    logic [3:0] ad;
    logic [3:0] vr;
    logic [7:0] st;
    logic [3:0] gn;
  } vec_t;

  vec_t sbq[$];
  int   vectors;
  int   miscompares;

  function automatic vec_t mk(logic [3:0] hs, logic rc, logic [3:0] vd, logic [3:0] ad,
                              logic [3:0] vr, logic [7:0] st, logic [3:0] gn);
    vec_t t;
    t.hs = hs; t.rc = rc; t.vd = vd; t.ad = ad; t.vr = vr; t.st = st; t.gn = gn;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    bus.hs_done  = t.hs;
    bus.rc_done  = t.rc;
    bus.vc_done  = t.vd;
    bus.all_done = t.ad;
    sbq.push_back(t);
  endtask

  task automatic do_reset();
    bus.hs_done = '0; bus.rc_done = 1'b0; bus.vc_done = '0; bus.all_done = '0;
    rs_n = 1'b0;
    #2 rs_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.hs_done = '0; bus.rc_done = 1'b0; bus.vc_done = '0; bus.all_done = '0;
    rs_n = 1'b0;
    #12;
    vectors += 2;
    if ({bus.state, bus.rc_gnt, bus.rc_busy, bus.wd_err} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_state got st=%h gnt=%b busy=%b wd=%b want all 0",
               bus.state, bus.rc_gnt, bus.rc_busy, bus.wd_err);
    end
    if (bus.vc_reset !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_vc_reset got %b want 1111", bus.vc_reset);
    end
    rs_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({bus.vc_reset, bus.state} !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_release got vc_reset=%b st=%h want 0 0", bus.vc_reset, bus.state);
    end
  endtask

  task automatic test_single();
    vec_t tbl[$];
    vec_t e;
    logic [3:0] vr;
    do_reset();
    tbl.push_back(mk(4'b0100, 0, 4'b0000, 4'b0000, 4'b0000, 8'h10, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 8'h10, 4'b0100));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 8'h20, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 4'b0100, 4'b0000, 4'b0000, 8'h30, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b0100, 4'b0100, 8'h00, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b0100, 4'b0000, 8'h00, 4'b0000));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1 vr = bus.vc_reset;
      @(posedge clk); #1;
      e = sbq.pop_front();
      vectors += 2;
      if (vr !== e.vr) begin
        miscompares++;
        $display("FAIL single[%0d] vc_reset got %b want %b", i, vr, e.vr);
      end
      if ({bus.state, bus.rc_gnt, bus.rc_busy, bus.wd_err} !== {e.st, e.gn, |e.gn, 4'b0}) begin
        miscompares++;
        $display("FAIL single[%0d] got st=%h gnt=%b busy=%b wd=%b want st=%h gnt=%b",
                 i, bus.state, bus.rc_gnt, bus.rc_busy, bus.wd_err, e.st, e.gn);
      end
    end
  endtask

  task automatic test_multi();
    vec_t tbl[$];
    vec_t e;
    logic [3:0] vr;
    do_reset();
    tbl.push_back(mk(4'b1011, 0, 4'b0000, 4'b0000, 4'b0000, 8'h45, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 8'h45, 4'b0001));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 8'h46, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 8'h46, 4'b0010));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 8'h4A, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 8'h4A, 4'b1000));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 8'h8A, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 4'b1001, 4'b0000, 4'b0000, 8'hCB, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b1001, 4'b1001, 8'h08, 4'b0000));
    tbl.push_back(mk(4'b1101, 0, 4'b0000, 4'b0000, 4'b0000, 8'h59, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 8'h59, 4'b0001));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 8'h5A, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 8'h5A, 4'b0100));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1 vr = bus.vc_reset;
      @(posedge clk); #1;
      e = sbq.pop_front();
      vectors += 2;
      if (vr !== e.vr) begin
        miscompares++;
        $display("FAIL multi[%0d] vc_reset got %b want %b", i, vr, e.vr);
      end
      if ({bus.state, bus.rc_gnt, bus.rc_busy, bus.wd_err} !== {e.st, e.gn, |e.gn, 4'b0}) begin
        miscompares++;
        $display("FAIL multi[%0d] got st=%h gnt=%b busy=%b wd=%b want st=%h gnt=%b",
                 i, bus.state, bus.rc_gnt, bus.rc_busy, bus.wd_err, e.st, e.gn);
      end
    end
  endtask

  task automatic test_ignore();
    vec_t tbl[$];
    vec_t e;
    logic [3:0] vr;
    do_reset();
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000));
    tbl.push_back(mk(4'b0001, 1, 4'b0000, 4'b0000, 4'b0000, 8'h01, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 8'h01, 4'b0001));
    tbl.push_back(mk(4'b0001, 0, 4'b0001, 4'b0001, 4'b0000, 8'h01, 4'b0001));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 8'h02, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 8'h02, 4'b0000));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1 vr = bus.vc_reset;
      @(posedge clk); #1;
      e = sbq.pop_front();
      vectors += 2;
      if (vr !== e.vr) begin
        miscompares++;
        $display("FAIL ignore[%0d] vc_reset got %b want %b", i, vr, e.vr);
      end
      if ({bus.state, bus.rc_gnt, bus.rc_busy, bus.wd_err} !== {e.st, e.gn, |e.gn, 4'b0}) begin
        miscompares++;
        $display("FAIL ignore[%0d] got st=%h gnt=%b busy=%b wd=%b want st=%h gnt=%b",
                 i, bus.state, bus.rc_gnt, bus.rc_busy, bus.wd_err, e.st, e.gn);
      end
    end
  endtask

  task automatic test_same_cycle();
    vec_t tbl[$];
    vec_t e;
    logic [3:0] vr;
    do_reset();
    tbl.push_back(mk(4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 8'h04, 4'b0000));
    tbl.push_back(mk(4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 8'h05, 4'b0010));
    tbl.push_back(mk(4'b0100, 1, 4'b0000, 4'b0000, 4'b0000, 8'h19, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 8'h19, 4'b0100));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 8'h29, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 8'h29, 4'b0001));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1 vr = bus.vc_reset;
      @(posedge clk); #1;
      e = sbq.pop_front();
      vectors += 2;
      if (vr !== e.vr) begin
        miscompares++;
        $display("FAIL same_cycle[%0d] vc_reset got %b want %b", i, vr, e.vr);
      end
      if ({bus.state, bus.rc_gnt, bus.rc_busy, bus.wd_err} !== {e.st, e.gn, |e.gn, 4'b0}) begin
        miscompares++;
        $display("FAIL same_cycle[%0d] got st=%h gnt=%b busy=%b wd=%b want st=%h gnt=%b",
                 i, bus.state, bus.rc_gnt, bus.rc_busy, bus.wd_err, e.st, e.gn);
      end
    end
  endtask

  task automatic test_mid_reset();
    vec_t tbl[$];
    vec_t e;
    do_reset();
    tbl.push_back(mk(4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 8'h01, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 8'h01, 4'b0001));
    tbl.push_back(mk(4'b0100, 1, 4'b0000, 4'b0000, 4'b0000, 8'h12, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 8'h13, 4'b0100));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      e = sbq.pop_front();
      vectors++;
      if ({bus.state, bus.rc_gnt, bus.rc_busy} !== {e.st, e.gn, |e.gn}) begin
        miscompares++;
        $display("FAIL mid_reset[%0d] got st=%h gnt=%b busy=%b want st=%h gnt=%b",
                 i, bus.state, bus.rc_gnt, bus.rc_busy, e.st, e.gn);
      end
    end
    drive(mk(4'b0000, 0, 4'b0000, 4'b0000, 4'b1111, 8'h00, 4'b0000));
    #2 rs_n = 1'b0;
    #1;
    e = sbq.pop_front();
    vectors += 2;
    if ({bus.state, bus.rc_gnt, bus.rc_busy} !== {e.st, e.gn, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_reset_async got st=%h gnt=%b busy=%b want st=%h gnt=%b",
               bus.state, bus.rc_gnt, bus.rc_busy, e.st, e.gn);
    end
    if (bus.vc_reset !== e.vr) begin
      miscompares++;
      $display("FAIL mid_reset_vc_reset got %b want %b", bus.vc_reset, e.vr);
    end
  endtask

`ifdef INPORT_WATCHDOG_EN
  task automatic test_watchdog();
    vec_t e;
    do_reset();
    bus.hs_done = 4'b1000;
    @(posedge clk); #1;
    bus.hs_done = 4'b0000;
    for (int k = 1; k <= 65; k++) begin
      sbq.push_back(mk(4'b0000, 0, 4'b0000, 4'b0000, (k == 65) ? 4'b0000 : 4'b1000,
                       (k < 64) ? 8'h40 : 8'h00, (k < 64) ? 4'b1000 : 4'b0000));
      @(posedge clk); #1;
      e = sbq.pop_front();
      vectors++;
      if ({bus.state, bus.rc_gnt} !== {e.st, e.gn} ||
          bus.wd_err !== ((k == 64) ? 4'b1000 : 4'b0000)) begin
        miscompares++;
        $display("FAIL watchdog[%0d] got st=%h gnt=%b wd=%b want st=%h gnt=%b",
                 k, bus.state, bus.rc_gnt, bus.wd_err, e.st, e.gn);
      end
    end
    bus.hs_done = 4'b1001;
    @(posedge clk); #1;
    bus.hs_done = 4'b0000;
    @(posedge clk); #1;
    vectors++;
    if (bus.rc_gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL watchdog_next_grant got %b want 0001", bus.rc_gnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_multi();
    test_ignore();
    test_same_cycle();
    test_mid_reset();
`ifdef INPORT_WATCHDOG_EN
    test_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
